// File: rtl/pulse_stretcher.sv
// Per-channel pulse stretcher: 1-cycle events become pulses with a minimum high time and a minimum low gap.
// Optional build macro PULSE_STRETCHER_RETRIGGER_EN: a request during HOLD restarts the hold time.
module pulse_stretcher #(
  parameter int WIDTH       = 1,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] busy
);

  // state | meaning
  // IDLE  | output low, waiting for a request
  // HOLD  | output high, counting down the hold time
  // GAP   | output low, counting down the forced gap; requests are remembered
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW     = $clog2(MAX_HG + 1);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic          HAS_GAP = (GAP_CYCLES > 0);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          pend, pend_n;
    logic          fin;
    logic          out_q, busy_q;

    always_comb begin
      state_n = state;
      cnt_n   = cnt;
      pend_n  = pend;
      fin     = 1'b0;
      case (state)
        IDLE: begin
          if (in[i]) begin
            state_n = HOLD;
            cnt_n   = HOLD_LD;
          end
        end
        HOLD: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
          if (in[i]) cnt_n = HOLD_LD;
          else if (tick) begin
`else
          pend_n = pend | in[i];
          if (tick) begin
`endif
            if (cnt != '0) cnt_n = cnt - CW'(1);
            else if (HAS_GAP) begin
              state_n = GAP;
              cnt_n   = GAP_LD;
            end else fin = 1'b1;
          end
        end
        GAP: begin
          pend_n = pend | in[i];
          if (tick) begin
            if (cnt != '0) cnt_n = cnt - CW'(1);
            else fin = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
      // End of the low gap (or of the hold when there is no gap): a remembered request starts the next pulse.
      if (fin) begin
        if (pend_n) begin
          state_n = HOLD;
          cnt_n   = HOLD_LD;
          pend_n  = 1'b0;
        end else begin
          state_n = IDLE;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state  <= IDLE;
        cnt    <= '0;
        pend   <= 1'b0;
        out_q  <= 1'b0;
        busy_q <= 1'b0;
      end else begin
        state  <= state_n;
        cnt    <= cnt_n;
        pend   <= pend_n;
        out_q  <= (state_n == HOLD);
        busy_q <= (state_n != IDLE);
      end
    end

    assign out[i]  = out_q;
    assign busy[i] = busy_q;
  end

endmodule
